fetch_sequencer: RTL

- Parametrised multi-cycle instruction sequencer. It is the next generation of the core's PC/fetch/branch/PSTATE control.
- It owns the PC, the NZCV status register, condition evaluation, halt and error reporting.
- It adds wait-state handshakes on instruction and data memory, plus timeout detection.
- It sits between instruction memory, the existing decoder/ALU/register file and data memory. It sequences one instruction at a time: FETCH -> EXEC -> (MEM) -> FETCH.

---
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle FETCH/EXEC/MEM sequencer owning PC, NZCV, halt and timeout errors.
// Define FETCH_SEQUENCER_PERF_EN to add the retired/stall_cycles performance counters.
module fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  output logic [ADDR_W-1:0] imem_a,
  output logic              imem_en,
  input  logic              imem_ready,
  input  logic [31:0]       imem_v,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              dec_branch,
  input  logic [3:0]        dec_cond,
  input  logic              dec_ldst,
  input  logic              dec_halt,
  input  logic              dec_setflags,
  input  logic [3:0]        alu_flags,
  input  logic [ADDR_W-1:0] br_target,
  output logic              dmem_req,
  input  logic              dmem_ready,
  output logic              wb_en,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        pstate,
  output logic [1:0]        error_indicator
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [31:0]       retired,
  output logic [31:0]       stall_cycles
`endif
);
  typedef enum logic [2:0] {FETCH, EXEC, MEM, HALT, ERROR} state_t;
  state_t state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic timed_out;
  logic n, z, c, v;
  logic base;
  logic taken;
  logic [ADDR_W-1:0] pc_seq;
  assign {n, z, c, v} = pstate;
  assign imem_a = pc;
  assign imem_en = state == FETCH;
  assign instr_valid = state == EXEC || state == MEM;
  assign dmem_req = state == MEM;
  assign wait_next = wait_cnt + 8'd1;
  assign timed_out = wait_next == 8'(TIMEOUT);
  assign pc_seq = pc + ADDR_W'(4);
  // Odd condition codes are the negation of the even code below them.
  always_comb begin
    base = 1'b1;
    case (dec_cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = n == v;
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    taken = dec_branch & (base ^ dec_cond[0]);
  end
  assign wb_en = clk_en & ((state == EXEC & ~dec_halt & ~dec_ldst) | (state == MEM & dmem_ready));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= PC_RESET;
      pstate <= '0;
      error_indicator <= 2'b00;
      instr <= 32'hC800_0000;
      wait_cnt <= '0;
`ifdef FETCH_SEQUENCER_PERF_EN
      retired <= '0;
      stall_cycles <= '0;
`endif
    end else if (clk_en) begin
`ifdef FETCH_SEQUENCER_PERF_EN
      if ((state == EXEC && (dec_halt || !dec_ldst)) || (state == MEM && dmem_ready))
        retired <= retired + 32'(retired != '1);
      if ((state == FETCH && !imem_ready) || (state == MEM && !dmem_ready))
        stall_cycles <= stall_cycles + 32'(stall_cycles != '1);
`endif
      case (state)
        FETCH: begin
          if (imem_ready) begin
            instr <= imem_v;
            state <= EXEC;
            wait_cnt <= '0;
          end else if (timed_out) begin
            error_indicator <= 2'b10;
            state <= ERROR;
            wait_cnt <= '0;
          end else wait_cnt <= wait_next;
        end
        EXEC: begin
          wait_cnt <= '0;
          if (dec_halt) begin
            error_indicator <= 2'b01;
            state <= HALT;
          end else begin
            if (dec_setflags) pstate <= alu_flags;
            if (dec_ldst) state <= MEM;
            else begin
              state <= FETCH;
              pc <= taken ? br_target & ~ADDR_W'(3) : pc_seq;
            end
          end
        end
        MEM: begin
          if (dmem_ready) begin
            pc <= pc_seq;
            state <= FETCH;
            wait_cnt <= '0;
          end else if (timed_out) begin
            error_indicator <= 2'b11;
            state <= ERROR;
            wait_cnt <= '0;
          end else wait_cnt <= wait_next;
        end
        default: ;
      endcase
    end
  end
endmodule
